// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
package adder_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  // Width of one carry-chain slice; zero stage count yields 0 so the config check can report it.
  function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
    return (stages == 32'd0) ? 32'd0 : width / stages;
  endfunction

endpackage

// File: rtl/add_slice.sv
// N-bit ripple-carry adder slice built from full-adder cells.
module add_slice #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder: the carry chain is cut into STAGES slices, one slice resolved per stage,
// with a per-stage valid/ready pipeline whose bubbles collapse.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned SW = slice_width(WIDTH, STAGES);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH || STAGES < 1 || STAGES > WIDTH ||
      (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] adv;

  // Operand/partial-sum view presented to each stage (stage 0 sees the ports).
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_sum [STAGES];
  logic [STAGES-1:0] st_c;

  assign st_a[0]   = a;
  assign st_b[0]   = b;
  assign st_sum[0] = '0;
  assign st_c[0]   = cin;

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]    s_sum;
    logic             s_cout;
    logic [WIDTH-1:0] nxt_sum;
    logic             v_r;
    logic             load;

    // Stage k stalls only when it and every stage after it are full and the sink is not ready.
    assign adv[k]  = out_ready || !(&v_q[STAGES-1:k]);
    assign load    = adv[k] && v_in[k];
    assign v_q[k]  = v_r;

    if (k == 0) begin : g_vin_head
      assign v_in[k] = in_valid;
    end else begin : g_vin_chain
      assign v_in[k] = v_q[k-1];
    end

    add_slice #(.N(SW)) u_slice (
      .a    (st_a[k][k*SW +: SW]),
      .b    (st_b[k][k*SW +: SW]),
      .cin  (st_c[k]),
      .sum  (s_sum),
      .cout (s_cout)
    );

    always_comb begin
      nxt_sum                = st_sum[k];
      nxt_sum[k*SW +: SW]    = s_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r <= 1'b0;
      end else if (adv[k]) begin
        v_r <= v_in[k];
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic [WIDTH-1:0] sum_r;
      logic             c_r;

      always_ff @(posedge clk) begin
        if (load) begin
          a_r   <= st_a[k];
          b_r   <= st_b[k];
          sum_r <= nxt_sum;
          c_r   <= s_cout;
        end
      end

      assign st_a[k+1]   = a_r;
      assign st_b[k+1]   = b_r;
      assign st_sum[k+1] = sum_r;
      assign st_c[k+1]   = c_r;
    end else begin : g_last
      // Final stage doubles as the output register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum   <= '0;
          carry <= 1'b0;
          ovf   <= 1'b0;
        end else if (load) begin
          sum   <= nxt_sum;
          carry <= s_cout;
          ovf   <= (st_a[k][WIDTH-1] == st_b[k][WIDTH-1]) &&
                   (s_sum[SW-1] != st_a[k][WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed vectors, streaming, backpressure,
// mid-stream reset and a parameter sweep, all against an arithmetic reference model.
module tb_pipe_adder;

  localparam int unsigned MW = 8;
  localparam int          MS = 2;

  typedef struct {
    longint unsigned sum;
    bit              carry;
    bit              ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] a;
  logic [MW-1:0] b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] sum;
  logic          carry;
  logic          ovf;

  pipe_adder #(.WIDTH(MW), .STAGES(MS)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   sweep_left = 3;
  logic sweep_go = 1'b0;

  exp_t       mq[$];
  int         occ = 0;
  int         acc_total = 0;
  bit         prev_stall = 1'b0;
  logic [10:0] prev_out;
  vec_t       vt[8];

  // Reference: plain integer arithmetic, signed overflow from the true signed result range.
  function automatic void ref_add(input int unsigned w, input longint unsigned x,
                                  input longint unsigned y, input bit ci,
                                  output longint unsigned s, output bit c, output bit v);
    longint unsigned tot, half;
    longint          sx, sy, st;
    half = 64'd1 << (w - 1);
    tot  = x + y + 64'(ci);
    s    = tot & ((half << 1) - 64'd1);
    c    = ((tot >> w) & 64'd1) != 64'd0;
    sx   = (x >= half) ? longint'(x) - longint'(half << 1) : longint'(x);
    sy   = (y >= half) ? longint'(y) - longint'(half << 1) : longint'(y);
    st   = sx + sy + longint'(ci);
    v    = (st >= longint'(half)) || (st < -longint'(half));
  endfunction

  task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // One beat into an empty pipe; measures latency and checks the result.
  task automatic send_one(input vec_t v, input int idx);
    int lat;
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    cin       = v.cin;
    out_ready = 1'b1;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'(MS));
    chk($sformatf("vec%0d_sum", idx), 64'(sum), 64'(v.sum));
    chk($sformatf("vec%0d_carry", idx), 64'(carry), 64'(v.carry));
    chk($sformatf("vec%0d_ovf", idx), 64'(ovf), 64'(v.ovf));
    @(posedge clk); #1;
  endtask

  // One clock of scoreboarded traffic on the main DUT (entered and left at posedge+1).
  task automatic cycle(input bit iv, input bit ordy, input bit strict);
    bit   acc, pop;
    exp_t e;
    in_valid  = iv;
    out_ready = ordy;
    a         = 8'($urandom);
    b         = 8'($urandom);
    cin       = 1'($urandom);
    #1;
    chk("in_ready", 64'(in_ready), 64'((occ < MS) || ordy));
    if (strict) chk("stream_valid", 64'(out_valid), 64'(acc_total >= MS));
    if (prev_stall) chk("hold", 64'({out_valid, sum, carry, ovf}), 64'(prev_out));
    pop = out_valid && ordy;
    if (pop) begin
      if (mq.size() == 0) begin
        fail("spurious_beat", $sformatf("got out_valid=1 sum=0x%0h expected no beat", sum));
      end else begin
        e = mq.pop_front();
        chk("result", 64'({sum, carry, ovf}), 64'({e.sum[7:0], e.carry, e.ovf}));
      end
    end
    acc = iv && in_ready;
    if (acc) begin
      ref_add(MW, 64'(a), 64'(b), cin, e.sum, e.carry, e.ovf);
      mq.push_back(e);
    end
    prev_stall = out_valid && !ordy;
    prev_out   = {out_valid, sum, carry, ovf};
    occ        = occ + int'(acc) - int'(pop);
    acc_total  = acc_total + int'(acc);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (mq.size() != 0 && n < 20) begin
      cycle(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk({name, "_left"}, 64'(mq.size()), 64'd0);
    chk({name, "_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[2] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vt[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #22;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // Release mid-cycle with a beat already offered: the first edge must take it.
    rst_n = 1'b1;
    send_one(vt[0], 100);
    for (int i = 0; i < 8; i++) send_one(vt[i], i);

    acc_total = 0;
    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, 1'b1);
    chk("stream_count", 64'(acc_total), 64'd256);
    drain("stream_drain");

    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    drain("bp_drain");

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 1'b0);
    drain("rand_drain");

    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_sum", 64'(sum), 64'd0);
    mq.delete();
    occ        = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_stale", 64'(out_valid), 64'd0);
      cycle(1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0);
    drain("post_rst_drain");

    sweep_go = 1'b1;
    n = 0;
    while (sweep_left != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (sweep_left != 0) fail("sweep_timeout", $sformatf("got %0d sweeps pending expected 0", sweep_left));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned W = (g == 0) ? 4 : (g == 1) ? 16 : 32;
    localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 4 : 8;

    logic         s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_carry, s_ovf;
    logic [W-1:0] s_a, s_b, s_sum;

    pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .a         (s_a),
      .b         (s_b),
      .cin       (s_cin),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .sum       (s_sum),
      .carry     (s_carry),
      .ovf       (s_ovf)
    );

    initial begin
      exp_t sq[$];
      exp_t e;
      int   lat, socc, n;
      bit   acc, pop;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      s_a         = '0;
      s_b         = '0;
      s_cin       = 1'b0;
      socc        = 0;
      wait (sweep_go);
      @(posedge clk); #1;

      s_in_valid = 1'b1;
      s_a        = W'($urandom);
      s_b        = W'($urandom);
      s_cin      = 1'($urandom);
      ref_add(W, 64'(s_a), 64'(s_b), s_cin, e.sum, e.carry, e.ovf);
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      lat = 1;
      while (!s_out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("sweep%0d_latency", g), 64'(lat), 64'(S));
      chk($sformatf("sweep%0d_first", g), 64'({s_sum, s_carry, s_ovf}),
          64'({e.sum[W-1:0], e.carry, e.ovf}));
      @(posedge clk); #1;

      for (int i = 0; i < 300; i++) begin
        s_out_ready = ($urandom_range(0, 3) != 0);
        s_in_valid  = ($urandom_range(0, 3) != 0);
        s_a         = W'($urandom);
        s_b         = W'($urandom);
        s_cin       = 1'($urandom);
        #1;
        chk($sformatf("sweep%0d_in_ready", g), 64'(s_in_ready), 64'((socc < int'(S)) || s_out_ready));
        pop = s_out_valid && s_out_ready;
        if (pop) begin
          if (sq.size() == 0) begin
            fail($sformatf("sweep%0d_spurious", g), "got out_valid=1 expected no beat");
          end else begin
            e = sq.pop_front();
            chk($sformatf("sweep%0d_result", g), 64'({s_sum, s_carry, s_ovf}),
                64'({e.sum[W-1:0], e.carry, e.ovf}));
          end
        end
        acc = s_in_valid && s_in_ready;
        if (acc) begin
          ref_add(W, 64'(s_a), 64'(s_b), s_cin, e.sum, e.carry, e.ovf);
          sq.push_back(e);
        end
        socc = socc + int'(acc) - int'(pop);
        @(posedge clk); #1;
      end

      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      n = 0;
      while (sq.size() != 0 && n < 100) begin
        #1;
        if (s_out_valid) begin
          e = sq.pop_front();
          chk($sformatf("sweep%0d_drain", g), 64'({s_sum, s_carry, s_ovf}),
              64'({e.sum[W-1:0], e.carry, e.ovf}));
        end
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("sweep%0d_left", g), 64'(sq.size()), 64'd0);
      sweep_left = sweep_left - 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by 300000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and sum width in bits; legal values are 2..64.
REQ-002 The block SHALL have parameter STAGES, default 2: number of pipeline stages; WIDTH mod STAGES == 0, and 1 <= STAGES <= WIDTH.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid SHALL be an input, 1 bit: operand beat present.
REQ-006 Port in_ready SHALL be an output, 1 bit: the block accepts a beat this cycle.
REQ-007 Port a SHALL be an input, WIDTH bits: operand A.
REQ-008 Port b SHALL be an input, WIDTH bits: operand B.
REQ-009 Port cin SHALL be an input, 1 bit: carry-in.
REQ-010 Port out_valid SHALL be an output, 1 bit: result beat present.
REQ-011 Port out_ready SHALL be an input, 1 bit: downstream accepts the result.
REQ-012 Port sum SHALL be an output, WIDTH bits: A+B+cin, modulo 2^WIDTH.
REQ-013 Port carry SHALL be an output, 1 bit: unsigned carry-out.
REQ-014 Port ovf SHALL be an output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The carry chain SHALL be split into STAGES slices of WIDTH/STAGES bits; slice k SHALL resolve in stage k, using the carry registered from slice k-1.
REQ-016 Operand bits not yet summed SHALL be carried forward in the pipeline registers, so that slice k sees a[k] and b[k] delayed by k cycles.
REQ-017 A beat SHALL be accepted on a rising edge when in_valid && in_ready.
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to out_valid, in the absence of stalls.
REQ-019 Throughput SHALL be one beat per cycle while out_ready is held at 1.
REQ-020 Each stage SHALL carry its own valid bit; stage k SHALL advance when it is empty or stage k+1 advances (the last stage advances when out_ready), so bubbles collapse.
REQ-021 in_ready SHALL equal the advance condition of stage 0; it is combinational from out_ready and the valid bits, with no combinational path from in_valid.
REQ-022 While out_valid && !out_ready, sum, carry, ovf and out_valid SHALL hold stable.
REQ-023 ovf SHALL equal (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]); cin is included in the sum.
REQ-024 Beats SHALL emerge in acceptance order, with none dropped or duplicated.
REQ-025 Data registers SHALL NOT be required to have a reset value; only the valid bits are reset.

Reset
REQ-026 While rst_n is 0, all stage valid bits SHALL clear asynchronously, giving out_valid=0 and in_ready=1.
REQ-027 sum, carry and ovf SHALL read 0 during reset; the output register is reset.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight beats; no result of a pre-reset beat may appear after reset.
REQ-029 Reset release SHALL take effect on the first rising clk edge with rst_n=1, and a beat SHALL be accepted on that edge.

Structure
REQ-030 A shared package adder_pkg SHALL hold the maximum WIDTH constant and a function computing slice width; no typedefs are required.
REQ-031 One sub-module, add_slice (a parametrised N-bit ripple adder with carry in and out, built from full-adder cells), SHALL be instantiated once per stage.
REQ-032 An elaboration-time check SHALL reject an illegal WIDTH/STAGES combination.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-033 Basic case: a=0x0F, b=0x01, cin=0, out_ready=1 -> 2 cycles later sum=0x10, carry=0, ovf=0.
REQ-034 Signed overflow and wrap: a=0x7F, b=0x01 -> sum=0x80, ovf=1; then a=0xFF, b=0x01, cin=1 -> sum=0x01, carry=1, ovf=0.
REQ-035 Back-to-back streaming: 256 random beats with out_ready=1 -> one result per cycle, all match the reference model, in order.
REQ-036 Backpressure: out_ready held 0 for 5 cycles with in_valid=1 -> in_ready drops once the pipe is full, the outputs hold, and the pipe drains without loss once out_ready returns to 1.
REQ-037 Reset mid-stream: rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, and no stale result afterwards.
REQ-038 Parameter sweep: (WIDTH, STAGES) = (4,1), (16,4), (32,8) -> exhaustive or random checks pass, with latency equal to STAGES.
